data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL provide parameter WORD_BYTES, default 2, bytes per memory word (2 or 4).
REQ-002 SHALL provide parameter ADDR_W, default 19, byte-address width.
REQ-003 SHALL provide parameter DEPTH, default 1024, number of words; word index wraps modulo DEPTH.
REQ-004 SHALL provide port clk  in  1  sole clock, rising edge.
REQ-005 SHALL provide port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL provide port req  in  1  CPU access request.
REQ-007 SHALL provide port we  in  1  1 = write, 0 = read.
REQ-008 SHALL provide port size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL provide port signed_ld  in  1  sign-extend loaded data.
REQ-010 SHALL provide port addr  in  ADDR_W  byte address.
REQ-011 SHALL provide port wdata  in  8*WORD_BYTES  store data, low bytes used.
REQ-012 SHALL provide port ready  out  1  request accepted this cycle.
REQ-013 SHALL provide port rvalid  out  1  one-cycle read-data strobe.
REQ-014 SHALL provide port rdata  out  8*WORD_BYTES  load result.
REQ-015 SHALL provide port err  out  1  one-cycle rejected-request strobe.
REQ-016 SHALL provide port pix_addr  in  ADDR_W  display byte address.
REQ-017 SHALL provide port pix_data  out  8  display byte, read-only port.

Function
REQ-018 Access is accepted on a rising edge when req=1 and ready=1; ready=1 exactly in state IDLE.
REQ-019 Byte order SHALL be little-endian; the lowest address maps to rdata/wdata[7:0].
REQ-020 nbytes = 1/2/4 for size 00/01/10; offset = addr mod WORD_BYTES; word = (addr / WORD_BYTES) mod DEPTH.
REQ-021 size=11, or size=10 with WORD_BYTES=2: err=1 the next cycle; no memory change; rvalid stays 0.
REQ-022 Access with offset+nbytes <= WORD_BYTES is aligned: the write uses byte enables and commits at the accept edge; a read sets rvalid=1 one cycle after accept.
REQ-023 Access with offset+nbytes > WORD_BYTES is split: beat 1 covers word, beat 2 covers word+1 (wrapping to 0 after DEPTH-1).
REQ-024 FSM states: IDLE and SPLIT. IDLE->SPLIT on accepting a split access; SPLIT->IDLE after one cycle unconditionally.
REQ-025 In SPLIT, ready=0 and req is ignored; a split read asserts rvalid two cycles after accept, with both beats assembled.
REQ-026 Read result is zero-extended from nbytes, or sign-extended from its MSB when signed_ld=1; rdata holds its value until the next rvalid.
REQ-027 pix_data = byte at pix_addr, registered, with 1-cycle latency, in every state.
REQ-028 On a same-cycle write to the byte at pix_addr, pix_data returns the old data.
REQ-029 err and rvalid are never both 1 in the same cycle.

Reset
REQ-030 While reset=0: state=IDLE, ready=1, rvalid=0, err=0, rdata=0, pix_data=0.
REQ-031 Memory contents are not cleared by reset.
REQ-032 Reset asserted in SPLIT aborts the access: beat 2 is not written, and no rvalid is issued.

Configuration
REQ-033 With macro DMEM_UNALIGNED_EN defined, split accesses behave per REQ-023..REQ-025.
REQ-034 With DMEM_UNALIGNED_EN undefined, any access meeting the split condition is rejected per REQ-021, SPLIT state is not built, and ready is constant 1 outside reset.

Verification (WORD_BYTES=2, DEPTH=1024)
REQ-035 Half write 0xBEEF @0x004, then half read @0x004 -> rvalid 1 cycle after accept, rdata=0xBEEF.
REQ-036 Byte write 0x5A @0x005, then half read @0x004 -> 0x5AEF; signed byte read @0x005 with byte 0x80 stored -> 0xFF80.
REQ-037 Macro on: half write 0x1234 @0x007 -> ready=0 for 1 cycle; byte 0x007=0x34, byte 0x008=0x12; half read @0x007 -> 0x1234 two cycles after accept.
REQ-038 Macro off: same write @0x007 -> err pulse, bytes 0x007/0x008 unchanged, ready stays 1.
REQ-039 Macro on: half write @0x7FF -> byte 0x7FF written and byte 0x000 written (word wrap); reset pulsed during SPLIT of a half write @0x003 -> byte 0x004 unchanged.
REQ-040 pix_addr=0x004 while half write 0x1111 @0x004 -> pix_data=old 0xEF next cycle, 0x11 the cycle after.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// data_mem_ctrl : little-endian byte-addressed data memory, CPU load/store port
//                 plus a registered read-only display byte port.
//                 Define DMEM_UNALIGNED_EN to service word-crossing accesses in
//                 two beats; without it such accesses are rejected with err.
// Revision      : 1.0
// ============================================================================
module data_mem_ctrl #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 19,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [1:0]              size,
    input  logic                    signed_ld,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [8*WORD_BYTES-1:0] wdata,
    output logic                    ready,
    output logic                    rvalid,
    output logic [8*WORD_BYTES-1:0] rdata,
    output logic                    err,
    input  logic [ADDR_W-1:0]       pix_addr,
    output logic [7:0]              pix_data
);
    localparam int DW     = 8 * WORD_BYTES;
    localparam int OFF_W  = $clog2(WORD_BYTES);
    localparam int WORD_W = $clog2(DEPTH);
    localparam int BE2_W  = 2 * WORD_BYTES;

    function automatic int nbytes_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return WORD_W'((32'(a) >> OFF_W) % 32'(DEPTH));
    endfunction

    function automatic logic [DW-1:0] extend(input logic [DW-1:0] raw,
                                             input logic [1:0]    sz,
                                             input logic          sgn);
        logic [DW-1:0] res;
        logic [7:0]    byt;
        logic          fill;
        int            nb;
        res  = '0;
        fill = 1'b0;
        nb   = nbytes_of(sz);
        for (int b = 0; b < WORD_BYTES; b++) begin
            byt = raw[8*b +: 8];
            if (b == nb - 1) fill = sgn & byt[7];
        end
        for (int b = 0; b < WORD_BYTES; b++) begin
            res[8*b +: 8] = (b < nb) ? raw[8*b +: 8] : {8{fill}};
        end
        return res;
    endfunction

    logic [DW-1:0]         mem_q [DEPTH];

    logic [OFF_W-1:0]      w_off;
    logic [WORD_W-1:0]     w_word;
    logic [BE2_W-1:0]      w_nmask;
    logic [BE2_W-1:0]      w_mask2;
    logic                  w_split;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_go;
    logic [DW-1:0]         w_wd_lo;
    logic [DW-1:0]         w_rd_raw;
    logic                  w_mem_we;
    logic [WORD_W-1:0]     w_mem_idx;
    logic [WORD_BYTES-1:0] w_mem_be;
    logic [DW-1:0]         w_mem_wd;
    logic                  w_rd_done;
    logic [DW-1:0]         w_rd_res;
    logic [DW-1:0]         w_pix_word;
    logic [7:0]            w_pix_byte;

    logic                  err_q;
    logic                  rvalid_q;
    logic [DW-1:0]         rdata_q;
    logic [7:0]            pix_q;

    assign w_off  = addr[OFF_W-1:0];
    assign w_word = word_of(addr);

    always_comb begin
        w_nmask = '0;
        for (int i = 0; i < BE2_W; i++) begin
            w_nmask[i] = (i < nbytes_of(size));
        end
    end

    // Byte enables spanning {word+1, word}; any upper-half bit means a split access.
    assign w_mask2  = w_nmask << w_off;
    assign w_split  = |w_mask2[BE2_W-1:WORD_BYTES];
    assign w_accept = req & ready;
    assign w_go     = w_accept & ~w_illegal;

`ifdef DMEM_UNALIGNED_EN
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [WORD_W-1:0]     w_next;
    logic [2*DW-1:0]       w_wd2;
    logic [WORD_W-1:0]     sp_word_q;
    logic [WORD_BYTES-1:0] sp_be_q;
    logic [DW-1:0]         sp_wd_q;
    logic [DW-1:0]         sp_lo_q;
    logic [OFF_W-1:0]      sp_off_q;
    logic [1:0]            sp_size_q;
    logic                  sp_we_q;
    logic                  sp_sgn_q;

    assign w_next    = (32'(w_word) == DEPTH - 1) ? '0 : w_word + 1'b1;
    assign w_illegal = (size == 2'b11) || (nbytes_of(size) > WORD_BYTES);
    assign w_wd2     = {{DW{1'b0}}, wdata} << {w_off, 3'b000};
    assign w_wd_lo   = w_wd2[DW-1:0];
    assign w_rd_raw  = DW'({mem_q[w_next], mem_q[w_word]} >> {w_off, 3'b000});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_go && w_split) state_d = SPLIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
    end

    // Beat-2 context; the low word is captured now so beat 2 only reads word+1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_word_q <= '0;
            sp_be_q   <= '0;
            sp_wd_q   <= '0;
            sp_lo_q   <= '0;
            sp_off_q  <= '0;
            sp_size_q <= '0;
            sp_we_q   <= 1'b0;
            sp_sgn_q  <= 1'b0;
        end else if (w_go && w_split) begin
            sp_word_q <= w_next;
            sp_be_q   <= w_mask2[BE2_W-1:WORD_BYTES];
            sp_wd_q   <= w_wd2[2*DW-1:DW];
            sp_lo_q   <= mem_q[w_word];
            sp_off_q  <= w_off;
            sp_size_q <= size;
            sp_we_q   <= we;
            sp_sgn_q  <= signed_ld;
        end
    end

    always_comb begin
        w_mem_we  = w_go & we;
        w_mem_idx = w_word;
        w_mem_be  = w_mask2[WORD_BYTES-1:0];
        w_mem_wd  = w_wd_lo;
        w_rd_done = w_go & ~we & ~w_split;
        w_rd_res  = extend(w_rd_raw, size, signed_ld);
        if (state_q == SPLIT) begin
            w_mem_we  = sp_we_q;
            w_mem_idx = sp_word_q;
            w_mem_be  = sp_be_q;
            w_mem_wd  = sp_wd_q;
            w_rd_done = ~sp_we_q;
            w_rd_res  = extend(DW'({mem_q[sp_word_q], sp_lo_q} >> {sp_off_q, 3'b000}),
                               sp_size_q, sp_sgn_q);
        end
    end
`else
    assign w_illegal = (size == 2'b11) || (nbytes_of(size) > WORD_BYTES) || w_split;
    assign w_wd_lo   = wdata << {w_off, 3'b000};
    assign w_rd_raw  = mem_q[w_word] >> {w_off, 3'b000};
    assign ready     = 1'b1;

    always_comb begin
        w_mem_we  = w_go & we;
        w_mem_idx = w_word;
        w_mem_be  = w_mask2[WORD_BYTES-1:0];
        w_mem_wd  = w_wd_lo;
        w_rd_done = w_go & ~we;
        w_rd_res  = extend(w_rd_raw, size, signed_ld);
    end
`endif

    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (w_mem_we && w_mem_be[b]) mem_q[w_mem_idx][8*b +: 8] <= w_mem_wd[8*b +: 8];
        end
    end

    assign w_pix_word = mem_q[word_of(pix_addr)];
    assign w_pix_byte = 8'(w_pix_word >> {pix_addr[OFF_W-1:0], 3'b000});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            pix_q    <= '0;
        end else begin
            err_q    <= w_accept & w_illegal;
            rvalid_q <= w_rd_done;
            if (w_rd_done) rdata_q <= w_rd_res;
            pix_q    <= w_pix_byte;
        end
    end

    assign err      = err_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign pix_data = pix_q;

endmodule
`default_nettype wire
